lsu_mem_master: RTL and testbench

- Load/store initiator that sits between the execute/memory pipeline stage and a byte-wide, synchronous-read, synchronous-write data memory.
- Accepts one request at a time: lw, lb, lbu, sw or sb.
- Serialises each request into single-byte memory cycles.
- Assembles, sign-extends or zero-extends load data and returns one response per request through a valid/ready handshake.

---
 rtl/lsu_mem_master.sv | 183 ++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator that turns one lw/lb/lbu/sw/sb request
// into single-byte cycles on a synchronous byte-wide memory and returns one
// response per request.
// Optional build macro: LSU_MISALIGN_TRAP_EN (misaligned word ops trap with
// resp_err instead of being silently aligned).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready is high only in IDLE; resp_valid is high only in RESP and
// resp_rdata/resp_err stay constant until the edge with resp_ready=1.
module lsu_mem_master #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_op,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_rdata,
    output logic                     resp_err,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic                     mem_re,
    output logic                     mem_we,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic [1:0]               dbg_state
);

    localparam int AW = ADDRESS_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DRAIN  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     op_q;
    logic [AW-1:0]  base_q;
    logic [31:0]    wdata_q;
    logic [1:0]     cnt_q;
    logic [31:0]    data_q;
    logic           err_q;
    logic           rd_pend_q;

    // Request decode on the raw inputs, only consumed in IDLE.
    logic           req_legal;
    logic           req_word;
    logic           trap_hit;
    logic           accept;
    logic [AW-1:0]  req_base;

    // Decode of the latched operation.
    logic           word_q;
    logic           store_q;
    logic [1:0]     last_cnt;
    logic [7:0]     store_byte;
    logic [31:0]    result;

    // Upper request address bits are deliberately ignored.
    logic           unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:AW];

    assign req_legal = (req_op == 3'b000) || (req_op == 3'b010) || (req_op == 3'b110) ||
                       (req_op == 3'b001) || (req_op == 3'b011);
    assign req_word  = (req_op[1] == 1'b0);
    assign req_base  = req_word ? {req_addr[AW-1:2], 2'b00} : req_addr[AW-1:0];
    assign accept    = (state_q == IDLE) && req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_hit = req_legal && req_word && (req_addr[1:0] != 2'b00);
`else
    assign trap_hit = 1'b0;
`endif

    assign word_q    = (op_q[1] == 1'b0);
    assign store_q   = op_q[0];
    assign last_cnt  = word_q ? 2'd3 : 2'd0;
    assign dbg_state = state_q;

    // Big-endian byte selection for stores; sb always writes the low byte.
    always_comb begin
        store_byte = wdata_q[7:0];
        if (word_q) begin
            case (cnt_q)
                2'd0:    store_byte = wdata_q[31:24];
                2'd1:    store_byte = wdata_q[23:16];
                2'd2:    store_byte = wdata_q[15:8];
                default: store_byte = wdata_q[7:0];
            endcase
        end
    end

    // Final load value from the assembled bytes; zero for stores and errors.
    always_comb begin
        result = 32'd0;
        if (!err_q) begin
            case (op_q)
                3'b000:  result = data_q;
                3'b010:  result = {{24{data_q[7]}}, data_q[7:0]};
                3'b110:  result = {24'd0, data_q[7:0]};
                default: result = 32'd0;
            endcase
        end
    end

    // Next state and all outputs; outputs are zero outside their owning state.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        mem_addr   = '0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (!req_legal || trap_hit) state_d = RESP;
                    else                        state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_addr = base_q + AW'(cnt_q);
                if (store_q) begin
                    mem_we    = 1'b1;
                    mem_wdata = store_byte;
                end else begin
                    mem_re = 1'b1;
                end
                if (cnt_q == last_cnt) state_d = store_q ? RESP : DRAIN;
            end
            DRAIN: begin
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = result;
                resp_err   = err_q;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and request/datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= 3'b000;
            base_q    <= '0;
            wdata_q   <= 32'd0;
            cnt_q     <= 2'd0;
            data_q    <= 32'd0;
            err_q     <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= mem_re;
            if (accept) begin
                op_q    <= req_op;
                base_q  <= req_base;
                wdata_q <= req_wdata;
                cnt_q   <= 2'd0;
                err_q   <= !req_legal || trap_hit;
            end else if (state_q == ACCESS) begin
                cnt_q <= cnt_q + 2'd1;
            end
            // A byte read issued last cycle is shifted in now, MSB first.
            if (accept) data_q <= 32'd0;
            else if (rd_pend_q) data_q <= {data_q[23:0], mem_rdata[7:0]};
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed plus randomized requests against a reference
// model of the load/store rules, with a synchronous byte memory attached.
module tb_lsu_mem_master;

  localparam int AW = 10;
  localparam int MSZ = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = 3'b000;
  logic [31:0]   req_addr = 32'd0;
  logic [31:0]   req_wdata = 32'd0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = 8'd0;
  logic [1:0]    dbg_state;

  lsu_mem_master #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- memory environment ----------------
  logic [7:0] env_mem [MSZ];
  logic [7:0] ref_mem [MSZ];

  always @(posedge clk) begin
    if (mem_we === 1'b1) env_mem[mem_addr] <= mem_wdata;
    if (mem_re === 1'b1) mem_rdata <= env_mem[mem_addr];
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  // Entry: {is_write, address, write byte (0 for reads)}
  logic [18:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every memory strobe must match the next expected access in order.
  always @(negedge clk) begin
    if (mem_we === 1'b1 || mem_re === 1'b1) begin
      logic [18:0] obs;
      logic [18:0] exp;
      obs = {mem_we, mem_addr, (mem_we === 1'b1) ? mem_wdata : 8'd0};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_mem_access observed=%h expected=none", obs);
      end else begin
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
          errors++;
          $error("FAIL mem_access observed=%h expected=%h", obs, exp);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Expected accesses, result, error and latency (edges after the accept edge
  // until resp_valid is seen) for one request.
  task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] e_rd, output logic e_err, output int e_lat);
    bit legal, word, store, trap;
    int base, n, a;
    logic [31:0] acc;
    legal = (op == 3'd0) || (op == 3'd2) || (op == 3'd6) || (op == 3'd1) || (op == 3'd3);
    word  = (op == 3'd0) || (op == 3'd1);
    store = (op == 3'd1) || (op == 3'd3);
    trap  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap  = legal && word && (addr % 4 != 0);
`endif
    e_rd = 32'd0; e_err = 1'b0; e_lat = 0;
    if (!legal || trap) begin
      e_err = 1'b1;
      return;
    end
    base = word ? int'(addr % MSZ) / 4 * 4 : int'(addr % MSZ);
    n = word ? 4 : 1;
    acc = 32'd0;
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      a = (base + i) % MSZ;
      if (store) begin
        b = word ? 8'(wd >> (8 * (3 - i))) : wd[7:0];
        ref_mem[a] = b;
        exp_q.push_back({1'b1, AW'(a), b});
      end else begin
        exp_q.push_back({1'b0, AW'(a), 8'd0});
        acc = (acc << 8) | 32'(ref_mem[a]);
      end
    end
    if (op == 3'd0) e_rd = acc;
    else if (op == 3'd2) e_rd = (acc[7] ? 32'hFFFF_FF00 : 32'd0) | acc;
    else if (op == 3'd6) e_rd = acc;
    e_lat = store ? n : n + 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload(input int a, input logic [7:0] v);
    env_mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_mem_re_we"}, {30'd0, mem_re, mem_we}, 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input int hold);
    logic [31:0] e_rd;
    logic e_err;
    int e_lat, lat;
    model(op, addr, wd, e_rd, e_err, e_lat);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    resp_ready = (hold == 0);
    @(negedge clk);
    // Garbage on the request inputs while busy must be ignored.
    req_valid = 1'($urandom_range(0, 1)); req_op = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 20) begin
      check("req_ready_busy", 32'(req_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(e_lat));
    for (int h = 0; h < hold; h++) begin
      check("hold_resp_valid", 32'(resp_valid), 32'd1);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_rdata", resp_rdata, e_rd);
      check("hold_err", 32'(resp_err), 32'(e_err));
      @(negedge clk);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_rdata", resp_rdata, e_rd);
    check("resp_err", 32'(resp_err), 32'(e_err));
    @(negedge clk);
    check("post_resp_valid", 32'(resp_valid), 32'd0);
    check("post_req_ready", 32'(req_ready), 32'd1);
    check("accesses_done", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] ops [6];
    logic [31:0] wd;
    ops[0] = 3'd0; ops[1] = 3'd2; ops[2] = 3'd6; ops[3] = 3'd1; ops[4] = 3'd3; ops[5] = 3'd5;
    for (int i = 0; i < MSZ; i++) preload(i, 8'($urandom));

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle");

    do_req(3'd1, 32'h10, 32'hDEAD_BEEF, 0);
    preload(32'h20, 8'h12); preload(32'h21, 8'h34);
    preload(32'h22, 8'h56); preload(32'h23, 8'h78);
    do_req(3'd0, 32'h22, 32'h0, 0);
    preload(32'h41, 8'h80);
    do_req(3'd2, 32'h41, 32'h0, 0);
    do_req(3'd6, 32'h41, 32'h0, 1);
    do_req(3'd3, 32'h3FF, 32'h0000_00A5, 0);
    do_req(3'd0, 32'h3FD, 32'h0, 0);
    do_req(3'd7, 32'h0, 32'hFFFF_FFFF, 3);
    do_req(3'd0, 32'hFFFF_F004, 32'h0, 0);
    do_req(3'd1, 32'h11, 32'hCAFE_F00D, 0);
    do_req(3'd0, 32'h10, 32'h0, 0);

    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 15)) | 32'h3F0;
      do_req(ops[$urandom_range(0, 5)], a, $urandom, $urandom_range(0, 2));
    end

    // Reset during the second write cycle of a store.
    wd = $urandom;
    exp_q.push_back({1'b1, AW'(10'h80), wd[31:24]});
    exp_q.push_back({1'b1, AW'(10'h81), wd[23:16]});
    ref_mem[10'h80] = wd[31:24];
    ref_mem[10'h81] = wd[23:16];
    req_valid = 1'b1; req_op = 3'd1; req_addr = 32'h80; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midop_reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("after_reset");
    check("reset_writes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    do_req(3'd0, 32'h80, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
